// File: rtl/ex_bypass_stage.sv
// RV32I execute stage: operand bypass from MEM/WB, ALU, branch/jump resolution
// and the EX/MEM pipeline register.
module ex_bypass_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            id_valid_i,
  input  logic [6:0]      id_opcode_i,
  input  logic [2:0]      id_funct3_i,
  input  logic            id_funct7b5_i,
  input  logic [4:0]      id_rs1_i,
  input  logic [4:0]      id_rs2_i,
  input  logic [4:0]      id_rd_i,
  input  logic [XLEN-1:0] id_rs1_val_i,
  input  logic [XLEN-1:0] id_rs2_val_i,
  input  logic [XLEN-1:0] id_imm_i,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic            wb_valid_i,
  input  logic            wb_regwrite_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_value_i,
  output logic            ex_valid_o,
  output logic            ex_regwrite_o,
  output logic            ex_is_load_o,
  output logic            ex_is_store_o,
  output logic [4:0]      ex_rd_o,
  output logic [2:0]      ex_funct3_o,
  output logic [6:0]      ex_opcode_o,
  output logic [XLEN-1:0] ex_alu_result_o,
  output logic [XLEN-1:0] ex_store_data_o,
  output logic            take_branch_o,
  output logic [XLEN-1:0] branch_target_o,
  output logic [1:0]      fwd_a_sel_o,
  output logic [1:0]      fwd_b_sel_o
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef struct packed {
    logic            valid;
    logic            regwrite;
    logic            is_load;
    logic            is_store;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [6:0]      opcode;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] store_data;
  } exmem_t;

  exmem_t ex_q, ex_d;

  // Operand bypass, index 0 = rs1 (A), 1 = rs2 (B). A load in MEM is never a
  // bypass source; the hazard unit inserts a bubble for that case.
  logic [1:0][4:0]      rs_idx;
  logic [1:0][XLEN-1:0] rs_val, opnd;
  logic [1:0][1:0]      fsel;

  assign rs_idx = {id_rs2_i, id_rs1_i};
  assign rs_val = {id_rs2_val_i, id_rs1_val_i};

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    logic mem_hit, wb_hit;
    assign mem_hit = ex_q.valid & ex_q.regwrite & ~ex_q.is_load &
                     (ex_q.rd != 5'd0) & (ex_q.rd == rs_idx[g]);
    assign wb_hit  = wb_valid_i & wb_regwrite_i & (wb_rd_i != 5'd0) & (wb_rd_i == rs_idx[g]);
    assign opnd[g] = mem_hit ? ex_q.alu_result : (wb_hit ? wb_value_i : rs_val[g]);
    assign fsel[g] = mem_hit ? 2'd1 : (wb_hit ? 2'd2 : 2'd0);
  end

  assign fwd_a_sel_o = fsel[0];
  assign fwd_b_sel_o = fsel[1];

  logic is_op, is_opimm, is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store;
  assign is_op     = (id_opcode_i == OPC_OP);
  assign is_opimm  = (id_opcode_i == OPC_OPIMM);
  assign is_lui    = (id_opcode_i == OPC_LUI);
  assign is_auipc  = (id_opcode_i == OPC_AUIPC);
  assign is_jal    = (id_opcode_i == OPC_JAL);
  assign is_jalr   = (id_opcode_i == OPC_JALR);
  assign is_branch = (id_opcode_i == OPC_BRANCH);
  assign is_load   = (id_opcode_i == OPC_LOAD);
  assign is_store  = (id_opcode_i == OPC_STORE);

  logic [XLEN-1:0] op_a, op_b, alu_b, alu_out, addr_sum, pc_imm, result;
  logic [4:0]      shamt;
  logic            use_imm, alu_lt_s, alu_lt_u, br_cond;

  assign op_a     = opnd[0];
  assign op_b     = opnd[1];
  assign use_imm  = is_opimm | is_load | is_store | is_jalr;
  assign alu_b    = use_imm ? id_imm_i : op_b;
  assign shamt    = alu_b[4:0];
  assign alu_lt_s = $signed(op_a) < $signed(alu_b);
  assign alu_lt_u = op_a < alu_b;
  assign addr_sum = op_a + id_imm_i;
  assign pc_imm   = id_pc_i + id_imm_i;

  always_comb begin
    alu_out = '0;
    case (id_funct3_i)
      3'b000:  alu_out = (is_op && id_funct7b5_i) ? op_a - alu_b : op_a + alu_b;
      3'b001:  alu_out = op_a << shamt;
      3'b010:  alu_out = {{(XLEN-1){1'b0}}, alu_lt_s};
      3'b011:  alu_out = {{(XLEN-1){1'b0}}, alu_lt_u};
      3'b100:  alu_out = op_a ^ alu_b;
      3'b101:  alu_out = id_funct7b5_i ? $unsigned($signed(op_a) >>> shamt) : op_a >> shamt;
      3'b110:  alu_out = op_a | alu_b;
      default: alu_out = op_a & alu_b;
    endcase
  end

  always_comb begin
    result = '0;
    if (is_op || is_opimm)          result = alu_out;
    else if (is_lui)                result = id_imm_i;
    else if (is_auipc)              result = pc_imm;
    else if (is_jal || is_jalr)     result = id_pc_i + XLEN'(4);
    else if (is_load || is_store)   result = addr_sum;
  end

  always_comb begin
    br_cond = 1'b0;
    case (id_funct3_i)
      3'b000:  br_cond = (op_a == op_b);
      3'b001:  br_cond = (op_a != op_b);
      3'b100:  br_cond = $signed(op_a) <  $signed(op_b);
      3'b101:  br_cond = $signed(op_a) >= $signed(op_b);
      3'b110:  br_cond = op_a <  op_b;
      3'b111:  br_cond = op_a >= op_b;
      default: br_cond = 1'b0;
    endcase
  end

  assign take_branch_o   = id_valid_i & ~stall_i & (is_jal | is_jalr | (is_branch & br_cond));
  assign branch_target_o = is_jalr ? {addr_sum[XLEN-1:1], 1'b0} : pc_imm;

  // Invalid slot captures an all-zero bubble.
  always_comb begin
    ex_d = '0;
    if (id_valid_i) begin
      ex_d.valid      = 1'b1;
      ex_d.regwrite   = is_op | is_opimm | is_lui | is_auipc | is_jal | is_jalr | is_load;
      ex_d.is_load    = is_load;
      ex_d.is_store   = is_store;
      ex_d.rd         = id_rd_i;
      ex_d.funct3     = id_funct3_i;
      ex_d.opcode     = id_opcode_i;
      ex_d.alu_result = result;
      ex_d.store_data = op_b;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)         ex_q <= '0;
    else if (!stall_i) ex_q <= ex_d;
  end

  assign ex_valid_o      = ex_q.valid;
  assign ex_regwrite_o   = ex_q.regwrite;
  assign ex_is_load_o    = ex_q.is_load;
  assign ex_is_store_o   = ex_q.is_store;
  assign ex_rd_o         = ex_q.rd;
  assign ex_funct3_o     = ex_q.funct3;
  assign ex_opcode_o     = ex_q.opcode;
  assign ex_alu_result_o = ex_q.alu_result;
  assign ex_store_data_o = ex_q.store_data;

endmodule

// File: tb/tb_ex_bypass_stage.sv
// Bench for ex_bypass_stage: directed RV32I scenarios plus randomized traffic
// against an instruction-level reference model.
module tb_ex_bypass_stage;

  logic        clk = 1'b0, rst = 1'b1, stall = 1'b0;
  logic        id_valid = 1'b0, id_f7 = 1'b0;
  logic [6:0]  id_op = '0;
  logic [2:0]  id_f3 = '0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic [31:0] id_v1 = '0, id_v2 = '0, id_imm = '0, id_pc = '0;
  logic        wb_valid = 1'b0, wb_rw = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_val = '0;

  logic        ex_valid, ex_rw, ex_ld, ex_st, take;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_f3;
  logic [6:0]  ex_op;
  logic [31:0] ex_res, ex_sd, tgt;
  logic [1:0]  sa, sb;

  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  ex_bypass_stage #(.XLEN(32)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .id_valid_i(id_valid),
    .id_opcode_i(id_op), .id_funct3_i(id_f3), .id_funct7b5_i(id_f7),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
    .id_rs1_val_i(id_v1), .id_rs2_val_i(id_v2), .id_imm_i(id_imm), .id_pc_i(id_pc),
    .wb_valid_i(wb_valid), .wb_regwrite_i(wb_rw), .wb_rd_i(wb_rd), .wb_value_i(wb_val),
    .ex_valid_o(ex_valid), .ex_regwrite_o(ex_rw), .ex_is_load_o(ex_ld), .ex_is_store_o(ex_st),
    .ex_rd_o(ex_rd), .ex_funct3_o(ex_f3), .ex_opcode_o(ex_op),
    .ex_alu_result_o(ex_res), .ex_store_data_o(ex_sd),
    .take_branch_o(take), .branch_target_o(tgt),
    .fwd_a_sel_o(sa), .fwd_b_sel_o(sb)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Expected architectural contents of the EX/MEM slot.
  typedef struct {
    bit          v, rw, ld, st;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  op;
    logic [31:0] res, sd;
  } slot_t;

  slot_t mdl = '{default: '0};
  slot_t e_nxt;
  logic [1:0]  e_sa, e_sb;
  logic        e_take;
  logic [31:0] e_tgt;

  function automatic logic [31:0] arith(logic [2:0] f3, bit sub_sra, bit is_reg,
                                        logic [31:0] a, logic [31:0] b);
    logic signed [31:0] sa_ = a;
    case (f3)
      3'd0:    return (is_reg && sub_sra) ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return (sa_ < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return sub_sra ? 32'(sa_ >>> b[4:0]) : a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  // Reference for one instruction given the current inputs and model slot.
  task automatic ref_eval();
    logic [31:0] a, b, res;
    bit rw, br, ld, st;
    a = id_v1; e_sa = 2'd0; b = id_v2; e_sb = 2'd0;
    if (wb_valid && wb_rw && wb_rd != 0 && wb_rd == id_rs1) begin a = wb_val; e_sa = 2'd2; end
    if (mdl.v && mdl.rw && !mdl.ld && mdl.rd != 0 && mdl.rd == id_rs1) begin a = mdl.res; e_sa = 2'd1; end
    if (wb_valid && wb_rw && wb_rd != 0 && wb_rd == id_rs2) begin b = wb_val; e_sb = 2'd2; end
    if (mdl.v && mdl.rw && !mdl.ld && mdl.rd != 0 && mdl.rd == id_rs2) begin b = mdl.res; e_sb = 2'd1; end
    res = 0; rw = 0; br = 0; ld = 0; st = 0; e_tgt = id_pc + id_imm;
    case (id_op)
      7'b0110011: begin res = arith(id_f3, id_f7, 1, a, b); rw = 1; end
      7'b0010011: begin res = arith(id_f3, id_f7, 0, a, id_imm); rw = 1; end
      7'b0110111: begin res = id_imm; rw = 1; end
      7'b0010111: begin res = id_pc + id_imm; rw = 1; end
      7'b1101111: begin res = id_pc + 4; rw = 1; br = 1; end
      7'b1100111: begin res = id_pc + 4; rw = 1; br = 1; e_tgt = (a + id_imm) & 32'hFFFF_FFFE; end
      7'b0000011: begin res = a + id_imm; rw = 1; ld = 1; end
      7'b0100011: begin res = a + id_imm; st = 1; end
      7'b1100011: case (id_f3)
        3'd0: br = (a == b);
        3'd1: br = (a != b);
        3'd4: br = $signed(a) < $signed(b);
        3'd5: br = $signed(a) >= $signed(b);
        3'd6: br = a < b;
        3'd7: br = a >= b;
        default: br = 0;
      endcase
      default: ;
    endcase
    e_take = id_valid && !stall && br;
    e_nxt = '{default: '0};
    if (id_valid) e_nxt = '{v: 1, rw: rw, ld: ld, st: st, rd: id_rd, f3: id_f3, op: id_op, res: res, sd: b};
  endtask

  task automatic apply(input string tag);
    #1;
    ref_eval();
    chk({tag, ".fwd_a"}, 32'(sa), 32'(e_sa));
    chk({tag, ".fwd_b"}, 32'(sb), 32'(e_sb));
    chk({tag, ".take"}, 32'(take), 32'(e_take));
    if (e_take) chk({tag, ".target"}, tgt, e_tgt);
  endtask

  task automatic check_slot(input string tag);
    chk({tag, ".ex_valid"}, 32'(ex_valid), 32'(mdl.v));
    chk({tag, ".ex_regwrite"}, 32'(ex_rw), 32'(mdl.rw));
    chk({tag, ".ex_is_load"}, 32'(ex_ld), 32'(mdl.ld));
    chk({tag, ".ex_is_store"}, 32'(ex_st), 32'(mdl.st));
    chk({tag, ".ex_rd"}, 32'(ex_rd), 32'(mdl.rd));
    chk({tag, ".ex_funct3"}, 32'(ex_f3), 32'(mdl.f3));
    chk({tag, ".ex_opcode"}, 32'(ex_op), 32'(mdl.op));
    chk({tag, ".ex_result"}, ex_res, mdl.res);
    chk({tag, ".ex_store_data"}, ex_sd, mdl.sd);
  endtask

  task automatic clock(input string tag);
    @(posedge clk);
    if (!stall) mdl = e_nxt;
    #1;
    check_slot(tag);
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input bit f7,
                       input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [31:0] v1, input logic [31:0] v2,
                       input logic [31:0] imm, input logic [31:0] pc);
    @(negedge clk);
    id_valid = 1; id_op = op; id_f3 = f3; id_f7 = f7; id_rd = rd;
    id_rs1 = r1; id_rs2 = r2; id_v1 = v1; id_v2 = v2; id_imm = imm; id_pc = pc;
  endtask

  logic [6:0] ops [10] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
                           7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011, 7'b0001011};

  initial begin
    #1;
    chk("reset.ex_valid", 32'(ex_valid), 0);
    chk("reset.ex_result", ex_res, 0);
    chk("reset.ex_regwrite", 32'(ex_rw), 0);
    @(negedge clk); rst = 0;

    // ADDI x1,x0,7 ; ADD x2,x1,x1 with stale regfile values
    issue(7'b0010011, 3'd0, 0, 5'd1, 5'd0, 5'd0, 0, 0, 32'd7, 32'h0);
    apply("addi7"); clock("addi7");
    issue(7'b0110011, 3'd0, 0, 5'd2, 5'd1, 5'd1, 0, 0, 0, 32'h4);
    apply("add_mem");
    chk("add_mem.sel_a_is_mem", 32'(sa), 1);
    clock("add_mem");
    chk("add_mem.result14", ex_res, 32'd14);

    // MEM ALU x3=200 beats WB x3=100
    issue(7'b0010011, 3'd0, 0, 5'd3, 5'd0, 5'd0, 0, 0, 32'd200, 32'h8);
    apply("addi200"); clock("addi200");
    wb_valid = 1; wb_rw = 1; wb_rd = 5'd3; wb_val = 32'd100;
    issue(7'b0110011, 3'd0, 1, 5'd4, 5'd3, 5'd0, 32'd9, 0, 0, 32'hC);
    apply("sub_mem");
    chk("sub_mem.sel_a", 32'(sa), 1);
    clock("sub_mem");
    chk("sub_mem.result200", ex_res, 32'd200);
    // load x3 in MEM: WB value is used instead
    wb_valid = 0;
    issue(7'b0000011, 3'd2, 0, 5'd3, 5'd0, 5'd0, 0, 0, 32'h40, 32'h10);
    apply("lw"); clock("lw");
    wb_valid = 1;
    issue(7'b0110011, 3'd0, 1, 5'd4, 5'd3, 5'd0, 32'd9, 0, 0, 32'h14);
    apply("sub_wb");
    chk("sub_wb.sel_a", 32'(sa), 2);
    clock("sub_wb");
    chk("sub_wb.result100", ex_res, 32'd100);

    // writes to x0 are never forwarded
    wb_valid = 0;
    issue(7'b0010011, 3'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 32'd55, 32'h18);
    apply("addi_x0"); clock("addi_x0");
    wb_valid = 1; wb_rd = 5'd0; wb_val = 32'd55;
    issue(7'b0110011, 3'd0, 0, 5'd5, 5'd0, 5'd0, 0, 0, 0, 32'h1C);
    apply("rd0");
    chk("rd0.sel_a", 32'(sa), 0);
    chk("rd0.sel_b", 32'(sb), 0);
    clock("rd0");
    chk("rd0.result", ex_res, 0);
    wb_valid = 0;

    // BLT / BLTU with A=-1, B=1
    issue(7'b1100011, 3'd4, 0, 5'd0, 5'd6, 5'd7, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF0, 32'h100);
    apply("blt");
    chk("blt.take", 32'(take), 1);
    chk("blt.target", tgt, 32'hF0);
    clock("blt");
    issue(7'b1100011, 3'd6, 0, 5'd0, 5'd6, 5'd7, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF0, 32'h100);
    apply("bltu");
    chk("bltu.take", 32'(take), 0);
    clock("bltu");

    // JALR x1, 2(x8) with x8=0x203, then the same under stall
    issue(7'b1100111, 3'd0, 0, 5'd1, 5'd8, 5'd0, 32'h203, 0, 32'd2, 32'h40);
    apply("jalr");
    chk("jalr.target", tgt, 32'h204);
    clock("jalr");
    chk("jalr.result", ex_res, 32'h44);
    issue(7'b0010011, 3'd0, 0, 5'd9, 5'd0, 5'd0, 0, 0, 32'd77, 32'h44);
    apply("addi77"); clock("addi77");
    issue(7'b1100111, 3'd0, 0, 5'd1, 5'd8, 5'd0, 32'h203, 0, 32'd2, 32'h40);
    stall = 1;
    apply("jalr_stall");
    chk("jalr_stall.take", 32'(take), 0);
    clock("jalr_stall");
    chk("jalr_stall.hold", ex_res, 32'd77);
    stall = 0;

    // randomized traffic with a reset in the middle
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (i == 300) begin
        rst = 1; #1;
        mdl = '{default: '0};
        chk("midrst.ex_valid", 32'(ex_valid), 0);
        chk("midrst.ex_result", ex_res, 0);
        chk("midrst.ex_regwrite", 32'(ex_rw), 0);
        #1 rst = 0;
        stall = 0; wb_valid = 0;
        id_valid = 1; id_op = 7'b0010011; id_f3 = 0; id_f7 = 0; id_rd = 5'd1;
        id_rs1 = 0; id_rs2 = 0; id_v1 = 0; id_v2 = 0; id_imm = 32'd5; id_pc = 32'h0;
        apply("postrst");
        clock("postrst");
        chk("postrst.result5", ex_res, 32'd5);
        continue;
      end
      id_valid = ($urandom_range(0, 7) != 0);
      stall    = ($urandom_range(0, 7) == 0);
      id_op    = ops[$urandom_range(0, 9)];
      id_f3    = 3'($urandom);
      id_f7    = 1'($urandom);
      id_rd    = 5'($urandom_range(0, 3));
      id_rs1   = 5'($urandom_range(0, 3));
      id_rs2   = 5'($urandom_range(0, 3));
      id_v1    = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
      id_v2    = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
      id_imm   = ($urandom_range(0, 1) != 0) ? $urandom : 32'($signed(12'($urandom)));
      id_pc    = $urandom & 32'hFFFF_FFFC;
      wb_valid = 1'($urandom);
      wb_rw    = 1'($urandom);
      wb_rd    = 5'($urandom_range(0, 3));
      wb_val   = $urandom;
      apply("rnd");
      clock("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ex_bypass_stage.md
# ex_bypass_stage

Execute stage of the 5-stage RV32I pipeline with integrated operand bypassing and branch/jump resolution. It takes the decoded instruction from the ID/EX register and selects forwarded operands from the MEM-stage instruction (held in its own EX/MEM output register) or the WB-stage result. It computes the ALU result, resolves branches and jumps into a redirect request for IF, and registers the result as the EX/MEM pipeline register.

## Interface
- XLEN, 32, datapath width (only 32 supported)
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all registered outputs
- stall  in  1  pipeline freeze (load-use, dcache or icache); EX/MEM register holds
- id_valid  in  1  ID/EX slot holds a real instruction
- id_opcode  in  7  RV32I major opcode
- id_funct3  in  3  funct3
- id_funct7b5  in  1  instr[30] (SUB/SRA select)
- id_rs1, id_rs2, id_rd  in  5 each  register indices
- id_rs1_val, id_rs2_val  in  32 each  register-file read values
- id_imm  in  32  sign-extended immediate, already formatted for the opcode
- id_pc  in  32  instruction PC
- wb_valid, wb_regwrite  in  1 each  WB-stage instruction valid / writes rd
- wb_rd  in  5  WB destination
- wb_value  in  32  final WB value (load data or ALU result)
- ex_valid, ex_regwrite, ex_is_load, ex_is_store  out  1 each  registered EX/MEM control
- ex_rd  out  5; ex_funct3  out  3; ex_opcode  out  7  registered
- ex_alu_result  out  32  registered result / memory address
- ex_store_data  out  32  registered forwarded rs2 value
- take_branch  out  1  combinational redirect request
- branch_target  out  32  combinational redirect PC
- fwd_a_sel, fwd_b_sel  out  2 each  combinational: 0 regfile, 1 MEM, 2 WB

## Operation
- Opcodes: OP 0110011, OP-IMM 0010011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011. Any other opcode is treated as a NOP: no regwrite, no branch.
- Forwarding for operand A (B identical with rs2):
  - MEM hit: ex_valid & ex_regwrite & !ex_is_load & ex_rd!=0 & ex_rd==id_rs1. Selects ex_alu_result, sel=1.
  - Otherwise WB hit: wb_valid & wb_regwrite & wb_rd!=0 & wb_rd==id_rs1. Selects wb_value, sel=2.
  - Otherwise id_rs1_val, sel=0. MEM has priority over WB.
  - Load in MEM feeding EX is never forwarded. The external hazard unit guarantees a bubble.
- ALU B operand is imm for OP-IMM/LOAD/STORE/JALR.
- ALU ops: ADD, SUB (OP only, funct7b5), SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - Shift amount is B[4:0].
  - OP-IMM SRAI uses funct7b5. SUB is never applied for OP-IMM.
- Results by opcode:
  - LUI: imm
  - AUIPC: pc+imm
  - JAL/JALR: pc+4
  - LOAD/STORE: rs1+imm (address)
  - BRANCH: 0, no regwrite
- Branch conditions on forwarded operands:
  - funct3 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU
  - 010/011 never taken
- Targets:
  - BRANCH and JAL: pc+imm
  - JALR: (A+imm) & ~1
- take_branch = id_valid & !stall & (JAL | JALR | taken BRANCH). branch_target is valid only when take_branch=1, otherwise don't-care (drive pc+imm).
- Flushing the younger IF/ID instructions on take_branch is done by the pipeline-register block, not here.
- ex_regwrite = id_valid & (OP|OP-IMM|LUI|AUIPC|JAL|JALR|LOAD). ex_is_load/ex_is_store decoded likewise.
- ex_store_data = forwarded B register value (never imm).
- All arithmetic is modulo 2^32; overflow is ignored.

## Timing
- Forward mux, ALU, take_branch and branch_target are combinational from the current-cycle inputs and the EX/MEM register.
- EX/MEM register: on posedge, if !stall, captures the computed values. If id_valid=0, captures a bubble: ex_valid=0, ex_regwrite=0, ex_is_load=0, ex_is_store=0, data fields 0. If stall, all outputs hold.
- Latency: 1 cycle from ID/EX inputs to ex_* outputs; 0 cycles to take_branch.
- Reset (async, any time): all ex_* outputs go to 0 immediately.
  - Combinational outputs follow the inputs.
  - The first cycle after reset sees no MEM forwarding, since ex_valid=0.
- Back-to-back dependent ALU ops forward through MEM with no stall. A 2-apart dependency forwards through WB.

## Test plan
- Reset asserted mid-run -> ex_valid=0, ex_alu_result=0, ex_regwrite=0 asynchronously; after release, first ADDI x1,x0,5 yields ex_alu_result=5 next cycle.
- ADDI x1,x0,7 then ADD x2,x1,x1 with stale rs vals 0 -> fwd_a_sel=fwd_b_sel=1, ex_alu_result=14.
- WB holds x3=100, MEM holds x3=200 (ALU), EX SUB x4,x3,x0 -> fwd_a_sel=1, result 200. With MEM holding a load to x3 instead -> fwd_a_sel=2, result 100.
- rd=0 writes in MEM/WB with value 55 and consumer reading x0 -> fwd sel 0, operand 0.
- BLT with pc=0x100, imm=-16, A=-1, B=1 -> take_branch=1, target 0xF0. BLTU with the same operands -> take_branch=0.
- JALR x1, rs1=0x203, imm=2, pc=0x40 -> target 0x204, ex_alu_result=0x44. Same instruction with stall=1 -> take_branch=0 and ex_* outputs hold their previous values.
